// File: rtl/movement_decoder.sv
// Player position tracker driven by a 16-bit one-hot movement code.
// Steps once on a new press, then auto-repeats on game ticks while the code
// is held; position saturates at the playfield edges.
module movement_decoder #(
  parameter int unsigned POS_W        = 8,
  parameter int unsigned X_MAX        = 159,
  parameter int unsigned Y_MAX        = 119,
  parameter int unsigned X_INIT       = 80,
  parameter int unsigned Y_INIT       = 60,
  parameter int unsigned STEP         = 1,
  parameter int unsigned REPEAT_DELAY = 8,
  parameter int unsigned REPEAT_RATE  = 2,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [15:0]      movement,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y,
  output logic             moved,
  output logic             blocked,
  output logic             bad_code
);

  localparam logic [POS_W:0]   StepW    = (POS_W+1)'(STEP);
  localparam logic [POS_W:0]   XMaxW    = (POS_W+1)'(X_MAX);
  localparam logic [POS_W:0]   YMaxW    = (POS_W+1)'(Y_MAX);
  localparam logic [POS_W-1:0] XInit    = POS_W'(X_INIT);
  localparam logic [POS_W-1:0] YInit    = POS_W'(Y_INIT);
  localparam logic [CNT_W-1:0] CntDelay = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] CntRate  = CNT_W'(REPEAT_RATE);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} state_e;

  state_e           state_q, state_d;
  logic [15:0]      mov_q;
  logic [15:0]      dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] pos_x_q, pos_y_q;
  logic [POS_W-1:0] x_next, y_next;
  logic             moved_q, blocked_q;
  logic             code_valid;
  logic             do_step;
  logic             pos_change;
  logic [POS_W:0]   x_inc, y_inc;
  logic [POS_W-1:0] x_inc_sat, y_inc_sat, x_dec_sat, y_dec_sat;

  // Classify the registered code; anything outside the four directions is "none".
  always_comb begin
    code_valid = 1'b0;
    case (mov_q)
      16'd1, 16'd2, 16'd4, 16'd8: code_valid = 1'b1;
      default:                    code_valid = 1'b0;
    endcase
  end

  assign bad_code = (mov_q != 16'd0) && !code_valid;

  // Saturating candidate positions, widened by one bit so an add cannot wrap.
  always_comb begin
    x_inc     = {1'b0, pos_x_q} + StepW;
    y_inc     = {1'b0, pos_y_q} + StepW;
    x_inc_sat = (x_inc > XMaxW) ? XMaxW[POS_W-1:0] : x_inc[POS_W-1:0];
    y_inc_sat = (y_inc > YMaxW) ? YMaxW[POS_W-1:0] : y_inc[POS_W-1:0];
    x_dec_sat = ({1'b0, pos_x_q} < StepW) ? '0 : pos_x_q - StepW[POS_W-1:0];
    y_dec_sat = ({1'b0, pos_y_q} < StepW) ? '0 : pos_y_q - StepW[POS_W-1:0];
  end

  // Select the stepped position for the current direction.
  always_comb begin
    x_next = pos_x_q;
    y_next = pos_y_q;
    case (mov_q)
      16'd1:   x_next = x_inc_sat;
      16'd2:   x_next = x_dec_sat;
      16'd4:   y_next = y_inc_sat;
      16'd8:   y_next = y_dec_sat;
      default: ;
    endcase
  end

  assign pos_change = (x_next != pos_x_q) || (y_next != pos_y_q);

  // Press / delay / repeat sequencing; a direction change restarts the delay.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    do_step = 1'b0;
    case (state_q)
      StIdle: begin
        if (code_valid) begin
          do_step = 1'b1;
          cnt_d   = CntDelay;
          dir_d   = mov_q;
          state_d = StDelay;
        end
      end
      StDelay, StRepeat: begin
        if (!code_valid) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (mov_q != dir_q) begin
          // Tick in this cycle is dropped: the immediate step owns it.
          do_step = 1'b1;
          cnt_d   = CntDelay;
          dir_d   = mov_q;
          state_d = StDelay;
        end else if (tick) begin
          if (cnt_q == CntOne) begin
            do_step = 1'b1;
            cnt_d   = CntRate;
            state_d = StRepeat;
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // State, input capture and position registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      mov_q     <= '0;
      dir_q     <= '0;
      cnt_q     <= '0;
      pos_x_q   <= XInit;
      pos_y_q   <= YInit;
      moved_q   <= 1'b0;
      blocked_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mov_q     <= movement;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      moved_q   <= do_step && pos_change;
      blocked_q <= do_step && !pos_change;
      if (do_step) begin
        pos_x_q <= x_next;
        pos_y_q <= y_next;
      end
    end
  end

  assign pos_x   = pos_x_q;
  assign pos_y   = pos_y_q;
  assign moved   = moved_q;
  assign blocked = blocked_q;

endmodule

// File: tb/tb_movement_decoder.sv
// Directed scoreboard bench for movement_decoder with default parameters.
module tb_movement_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic [15:0] movement;
  logic [7:0]  pos_x, pos_y;
  logic        moved, blocked, bad_code;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  movement_decoder dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .movement (movement),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .moved    (moved),
    .blocked  (blocked),
    .bad_code (bad_code)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop(input logic [31:0] obs);
    exp_t e;
    total++;
    assert (sb.size() != 0) else begin
      bad++;
      $error("FAIL sb_empty observed=%0d required=entry", obs);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%0d required=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic expect5(input string tag, input int x, input int y, input int mv,
                         input int bl, input int bd);
    push({tag, "_x"}, x);
    push({tag, "_y"}, y);
    push({tag, "_moved"}, mv);
    push({tag, "_blocked"}, bl);
    push({tag, "_bad"}, bd);
  endtask

  task automatic observe5();
    pop(32'(pos_x));
    pop(32'(pos_y));
    pop(32'(moved));
    pop(32'(blocked));
    pop(32'(bad_code));
  endtask

  task automatic cyc(input logic t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  initial begin
    int nb;
    int ey;
    int em;
    rst      = 1'b0;
    tick     = 1'b0;
    movement = '0;
    #2 rst = 1'b1;
    expect5("rst", 80, 60, 0, 0, 0);
    @(posedge clk);
    #1;
    observe5();
    rst = 1'b0;

    // Single-cycle press with no ticks: exactly one step, two edges later.
    movement = 16'd1;
    expect5("pulse_a", 80, 60, 0, 0, 0);
    cyc(1'b0);
    observe5();
    movement = 16'd0;
    expect5("pulse_b", 81, 60, 1, 0, 0);
    cyc(1'b0);
    observe5();
    for (int i = 0; i < 4; i++) begin
      expect5("pulse_idle", 81, 60, 0, 0, 0);
      cyc(1'b0);
      observe5();
    end

    // Held up with a tick every 4 clocks: delay of 8 ticks, then every 2 ticks.
    movement = 16'd8;
    expect5("up_a", 81, 60, 0, 0, 0);
    cyc(1'b0);
    observe5();
    expect5("up_first", 81, 59, 1, 0, 0);
    cyc(1'b0);
    observe5();
    for (int k = 1; k <= 16; k++) begin
      cyc(1'b0);
      cyc(1'b0);
      cyc(1'b0);
      ey = 59 - ((k >= 8) ? 1 + (k - 8) / 2 : 0);
      em = ((k == 8) || (k > 8 && ((k - 8) % 2) == 0)) ? 1 : 0;
      push("up_rep_y", ey);
      push("up_rep_moved", em);
      cyc(1'b1);
      pop(32'(pos_y));
      pop(32'(moved));
    end
    movement = 16'd0;
    cyc(1'b0);
    for (int i = 0; i < 4; i++) begin
      push("up_release_y", 54);
      push("up_release_moved", 0);
      cyc(1'b1);
      pop(32'(pos_y));
      pop(32'(moved));
    end

    // Right edge: run to 159, then further steps only pulse blocked.
    movement = 16'd1;
    for (int i = 0; i < 400 && pos_x != 8'd159; i++) cyc(1'b1);
    push("x_reach", 159);
    pop(32'(pos_x));
    nb = 0;
    for (int i = 0; i < 6; i++) begin
      push("x_edge_moved", 0);
      push("x_edge_hold", 159);
      cyc(1'b1);
      pop(32'(moved));
      pop(32'(pos_x));
      if (blocked) nb++;
    end
    push("x_blocked_cnt", 3);
    pop(32'(nb));
    movement = 16'd0;
    for (int i = 0; i < 3; i++) cyc(1'b1);

    // Top edge: run to 0, no wrap to 255.
    movement = 16'd8;
    for (int i = 0; i < 400 && pos_y != 8'd0; i++) cyc(1'b1);
    push("y_reach", 0);
    pop(32'(pos_y));
    nb = 0;
    for (int i = 0; i < 6; i++) begin
      push("y_edge_moved", 0);
      push("y_edge_hold", 0);
      cyc(1'b1);
      pop(32'(moved));
      pop(32'(pos_y));
      if (blocked) nb++;
    end
    push("y_blocked_cnt", 3);
    pop(32'(nb));
    movement = 16'd0;
    for (int i = 0; i < 3; i++) cyc(1'b0);

    // Invalid codes flag bad_code and behave as no key.
    movement = 16'd3;
    expect5("bad3_a", 159, 0, 0, 0, 1);
    cyc(1'b0);
    observe5();
    for (int i = 0; i < 2; i++) begin
      expect5("bad3_hold", 159, 0, 0, 0, 1);
      cyc(1'b1);
      observe5();
    end
    movement = 16'h0010;
    for (int i = 0; i < 2; i++) begin
      expect5("bad10", 159, 0, 0, 0, 1);
      cyc(1'b1);
      observe5();
    end
    movement = 16'd0;
    expect5("bad_clear", 159, 0, 0, 0, 0);
    cyc(1'b0);
    observe5();

    // Direction change mid-delay: immediate step, delay timer restarts.
    movement = 16'd2;
    expect5("left_a", 159, 0, 0, 0, 0);
    cyc(1'b0);
    observe5();
    expect5("left_step", 158, 0, 1, 0, 0);
    cyc(1'b0);
    observe5();
    for (int i = 0; i < 3; i++) begin
      expect5("left_delay", 158, 0, 0, 0, 0);
      cyc(1'b1);
      observe5();
    end
    movement = 16'd4;
    cyc(1'b0);
    expect5("switch_step", 158, 1, 1, 0, 0);
    cyc(1'b1);
    observe5();
    for (int i = 0; i < 7; i++) begin
      expect5("switch_delay", 158, 1, 0, 0, 0);
      cyc(1'b1);
      observe5();
    end
    expect5("switch_repeat", 158, 2, 1, 0, 0);
    cyc(1'b1);
    observe5();

    // Reset mid-repeat returns outputs at once; a held key is a new press after.
    for (int i = 0; i < 6; i++) cyc(1'b1);
    #3;
    rst = 1'b1;
    #1;
    expect5("rst_mid", 80, 60, 0, 0, 0);
    observe5();
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect5("post_rst_a", 80, 60, 0, 0, 0);
    cyc(1'b0);
    observe5();
    expect5("post_rst_press", 80, 61, 1, 0, 0);
    cyc(1'b0);
    observe5();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
